key_expand128_inv: RTL and testbench
====================================

KEY_EXPAND128_INV -- requirements
Module: key_expand128_inv

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have kl, input, 128 ([0:127], word w40 at [0:31]), last (round-10) AES-128 round key.
REQ-004 SHALL have kl_vld, input, 1, kl holds a valid key.
REQ-005 SHALL have kl_rdy, output, 1, block accepts a new key this cycle.
REQ-006 SHALL have rkey, output, 128 ([0:127]), current round key, MSB-first words w0..w3.
REQ-007 SHALL have rkey_idx, output, 4, round number of rkey (10 down to 0).
REQ-008 SHALL have rkey_vld, output, 1, rkey/rkey_idx valid.
REQ-009 SHALL have rkey_rdy, input, 1, consumer accepts rkey this cycle.
REQ-010 SHALL have rkey_last, output, 1, rkey is round key 0 (the original cipher key).

Function
REQ-011 SHALL implement a two-state FSM: IDLE and RUN, with a 4-bit round counter idx and an 8-bit Rcon register.
REQ-012 SHALL, in IDLE, drive kl_rdy=1 and rkey_vld=0.
REQ-013 SHALL, in IDLE on kl_vld=1, load kl into word registers w0..w3, set idx=10 and Rcon=8'h36, and enter RUN.
REQ-014 SHALL drive kl_rdy=0 throughout RUN, so kl_vld is ignored there.
REQ-015 SHALL, in RUN, drive rkey={w0,w1,w2,w3}, rkey_idx=idx and rkey_vld=1; first rkey_vld is exactly 1 cycle after the accept cycle.
REQ-016 SHALL hold rkey, rkey_idx and Rcon stable while rkey_vld=1 and rkey_rdy=0, with no limit on stall length.
REQ-017 SHALL, on a RUN transfer (rkey_rdy=1) with idx>0, load the previous round key, decrement idx and step Rcon backward.
REQ-018 SHALL compute the previous round key combinationally:
- p3=w3^w2
- p2=w2^w1
- p1=w1^w0
- p0=w0^SubWord(RotWord(p3))^{Rcon,24'h0}
REQ-019 SHALL step Rcon backward as: if Rcon==8'h1b then 8'h80, else Rcon>>1. The sequence used is 36,1b,80,40,20,10,08,04,02,01.
REQ-020 SHALL drive rkey_last=1 iff in RUN with idx==0.
REQ-021 SHALL, on a transfer with idx==0, return to IDLE; the next key accept is possible the following cycle (1 bubble between keys).
REQ-022 SHALL sustain one round key per cycle when rkey_rdy is held high: 11 keys in 11 consecutive cycles.
REQ-023 SHALL produce exactly 11 transfers per accepted key, idx strictly 10..0, never wrapping below 0.

Reset
REQ-024 SHALL, on rst, force IDLE, idx=0, Rcon=8'h36, w0..w3=0, regardless of the current state (including mid-RUN).
REQ-025 SHALL have these output values during and after reset: kl_rdy=1, rkey_vld=0, rkey_last=0, rkey=0, rkey_idx=0.
REQ-026 SHALL give rst priority over a simultaneous kl_vld or rkey_rdy.

Structure
REQ-027 SHALL take from the shared AES package: the FSM state enum, the constants RCON_LAST=8'h36 and NUM_ROUNDS=10, and the backward-Rcon function.
REQ-028 SHALL instantiate one sub-module aes_sub_word (4 parallel S-boxes, 32-bit combinational) for SubWord.
REQ-029 SHALL perform RotWord by wiring only.

Verification
REQ-030 SHALL cover FIPS-197 A.1: kl=d014f9a8c9ee2589e13f0cc8b6630ca6, rkey_rdy=1. Required response:
- cycle+1: rkey=kl, idx=10
- cycle+2: ac7766f319fadc2128d12941575c006e, idx=9
- cycle+11: 2b7e151628aed2a6abf7158809cf4f3c, idx=0, rkey_last=1
REQ-031 SHALL cover backpressure: the same key with rkey_rdy randomly toggled. Required: identical 11-key sequence, and rkey held unchanged during every stall.
REQ-032 SHALL cover ignore-while-busy: pulse kl_vld with a different key during RUN. Required: kl_rdy=0 and the sequence is unaffected.
REQ-033 SHALL cover reset mid-operation: rst asserted at idx=5. Required: next cycle rkey_vld=0, kl_rdy=1; a new key then produces a full 10..0 sequence starting with Rcon=36.
REQ-034 SHALL cover back-to-back keys: kl_vld held high with two keys. Required: the second key is accepted on the cycle after rkey_last transfers, and its first rkey appears 1 cycle later.
REQ-035 SHALL cover a forward/inverse cross-check: 1000 random cipher keys expanded by a reference model. Required: reversed output matches all 11 round keys.

Source files
------------

// File: rtl/key_expand128_inv_pkg.sv
// Shared AES definitions for the inverse key schedule: FSM states, round
// constants, backward Rcon stepping and the forward S-box.
package key_expand128_inv_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  // S-box flattened MSB-first: entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Rcon walks backward through 36,1b,80,40,...,01; 1b is the only
  // value that does not come from a plain right shift.
  function automatic logic [7:0] rcon_prev(input logic [7:0] rcon);
    return (rcon == 8'h1b) ? 8'h80 : {1'b0, rcon[7:1]};
  endfunction

endpackage

// File: rtl/key_expand128_inv_sub_word.sv
// SubWord: four parallel AES S-boxes on a 32-bit word, purely combinational.
module aes_sub_word
  import key_expand128_inv_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
  end

endmodule

// File: rtl/key_expand128_inv.sv
// Inverse AES-128 key schedule: takes the round-10 key and streams round
// keys 10 down to 0, one per accepted transfer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a last-round key; kl_rdy=1, no output valid
//   ST_RUN  | presenting round key idx; steps back on each rkey_rdy
module key_expand128_inv
  import key_expand128_inv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] kl,
  input  logic         kl_vld,
  output logic         kl_rdy,
  output logic [127:0] rkey,
  output logic [3:0]   rkey_idx,
  output logic         rkey_vld,
  input  logic         rkey_rdy,
  output logic         rkey_last
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;

  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sub_rot_p3;

  // p3 is the last word of the previous round key, which is what the
  // forward schedule fed through RotWord/SubWord to build w0.
  assign p3 = w3_q ^ w2_q;
  assign p2 = w2_q ^ w1_q;
  assign p1 = w1_q ^ w0_q;

  aes_sub_word u_sub_word (
    .word_i ({p3[23:0], p3[31:24]}),
    .word_o (sub_rot_p3)
  );

  assign p0 = w0_q ^ sub_rot_p3 ^ {rcon_q, 24'h0};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rcon_d   = rcon_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    w2_d     = w2_q;
    w3_d     = w3_q;
    kl_rdy   = 1'b0;
    rkey_vld = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        kl_rdy = 1'b1;
        if (kl_vld) begin
          w0_d    = kl[127:96];
          w1_d    = kl[95:64];
          w2_d    = kl[63:32];
          w3_d    = kl[31:0];
          idx_d   = NUM_ROUNDS;
          rcon_d  = RCON_LAST;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rkey_vld = 1'b1;
        if (rkey_rdy) begin
          if (idx_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            w0_d   = p0;
            w1_d   = p1;
            w2_d   = p2;
            w3_d   = p3;
            idx_d  = idx_q - 4'd1;
            rcon_d = rcon_prev(rcon_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_LAST;
      w0_q    <= 32'h0;
      w1_q    <= 32'h0;
      w2_q    <= 32'h0;
      w3_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
    end
  end

  // Outputs read as zero outside RUN so the IDLE view never leaks a stale key.
  assign rkey      = (state_q == ST_RUN) ? {w0_q, w1_q, w2_q, w3_q} : 128'h0;
  assign rkey_idx  = (state_q == ST_RUN) ? idx_q : 4'd0;
  assign rkey_last = (state_q == ST_RUN) && (idx_q == 4'd0);

endmodule

// File: tb/tb_key_expand128_inv.sv
// Bench for key_expand128_inv: GF(2^8)-derived AES key schedule model,
// per-cycle monitor and directed plus randomized key streams.
module tb_key_expand128_inv;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] kl;
  logic         kl_vld;
  logic         kl_rdy;
  logic [127:0] rkey;
  logic [3:0]   rkey_idx;
  logic         rkey_vld;
  logic         rkey_rdy;
  logic         rkey_last;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9   = 128'hac7766f319fadc2128d12941575c006e;

  key_expand128_inv dut (
    .clk       (clk),
    .rst       (rst),
    .kl        (kl),
    .kl_vld    (kl_vld),
    .kl_rdy    (kl_rdy),
    .rkey      (rkey),
    .rkey_idx  (rkey_idx),
    .rkey_vld  (rkey_vld),
    .rkey_rdy  (rkey_rdy),
    .rkey_last (rkey_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [131:0] act, input logic [131:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_sbox [256];
  logic [7:0]  m_rcon [1:10];
  logic [31:0] mw_i [44];
  logic [31:0] mw_f [44];
  logic [127:0] fwd_rk [0:10];
  bit          fwd_on = 1'b0;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic build_model();
    logic [7:0] inv, r, s, rc;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      m_sbox[v] = s ^ 8'h63;
    end
    rc = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      m_rcon[k] = rc;
      rc = xtime(rc);
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {m_sbox[r[31:24]], m_sbox[r[23:16]], m_sbox[r[15:8]], m_sbox[r[7:0]]};
  endfunction

  // Forward FIPS-197 expansion of a cipher key into fwd_rk[0..10].
  task automatic expand_fwd(input logic [127:0] key);
    logic [31:0] t;
    for (int j = 0; j < 4; j++) mw_f[j] = key[127-32*j -: 32];
    for (int i = 4; i < 44; i++) begin
      t = mw_f[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {m_rcon[i/4], 24'h0};
      mw_f[i] = mw_f[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      fwd_rk[r] = {mw_f[4*r], mw_f[4*r+1], mw_f[4*r+2], mw_f[4*r+3]};
  endtask

  // Undo the forward recurrence starting from the last four words.
  task automatic expand_inv(input logic [127:0] last);
    for (int j = 0; j < 4; j++) mw_i[40+j] = last[127-32*j -: 32];
    for (int i = 39; i >= 0; i--) begin
      if ((i + 4) % 4 == 0) mw_i[i] = mw_i[i+4] ^ sub_rot(mw_i[i+3]) ^ {m_rcon[(i+4)/4], 24'h0};
      else                  mw_i[i] = mw_i[i+4] ^ mw_i[i+3];
    end
  endtask

  function automatic logic [127:0] inv_round(input int r);
    return {mw_i[4*r], mw_i[4*r+1], mw_i[4*r+2], mw_i[4*r+3]};
  endfunction

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } req_t;
  req_t exp_q[$];

  // ---------------- per-cycle monitor ----------------
  bit           rst_prev   = 1'b1;
  bit           first_pend = 1'b0;
  bit           hold_v     = 1'b0;
  bit           after_last = 1'b0;
  logic [127:0] held_key;
  logic [3:0]   held_idx;

  always @(negedge clk) begin
    req_t e;
    if (rst_prev) begin
      chk(!rkey_vld && kl_rdy && !rkey_last && rkey_idx == 4'd0, "reset_ctl",
          {rkey_vld, kl_rdy, rkey_last, rkey_idx}, {1'b0, 1'b1, 1'b0, 4'd0});
      chk(rkey == 128'h0, "reset_rkey", rkey, 0);
    end else begin
      chk(kl_rdy == !rkey_vld, "rdy_vs_vld", kl_rdy, !rkey_vld);
      chk(rkey_last == (rkey_vld && rkey_idx == 4'd0), "last_flag",
          rkey_last, (rkey_vld && rkey_idx == 4'd0));
      if (first_pend)
        chk(rkey_vld && rkey_idx == 4'd10, "first_latency", {rkey_vld, rkey_idx}, {1'b1, 4'd10});
      if (hold_v)
        chk(rkey == held_key && rkey_idx == held_idx, "stall_hold",
            {rkey_idx, rkey}, {held_idx, held_key});
      if (after_last)
        chk(!rkey_vld, "bubble", rkey_vld, 0);
      if (rkey_vld && rkey_rdy) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_transfer", {rkey_idx, rkey}, 0);
        end else begin
          e = exp_q.pop_front();
          chk(rkey == e.key && rkey_idx == e.idx, "round_key",
              {rkey_idx, rkey}, {e.idx, e.key});
        end
        if (fwd_on && rkey_idx <= 4'd10)
          chk(rkey == fwd_rk[rkey_idx], "fwd_xcheck", rkey, fwd_rk[rkey_idx]);
      end
    end
    after_last = !rst && !rst_prev && rkey_vld && rkey_rdy && rkey_idx == 4'd0;
    hold_v     = !rst && !rst_prev && rkey_vld && !rkey_rdy;
    held_key   = rkey;
    held_idx   = rkey_idx;
    first_pend = !rst && kl_vld && kl_rdy;
    if (rst) exp_q.delete();
    if (first_pend) begin
      expand_inv(kl);
      for (int r = 10; r >= 0; r--) exp_q.push_back('{inv_round(r), 4'(r)});
    end
    rst_prev = rst;
  end

  // ---------------- driver ----------------
  task automatic step(input bit rnd);
    @(posedge clk);
    #1;
    rkey_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Leaves kl_vld high; returns the cycle number just after the accept edge.
  task automatic accept_key(input logic [127:0] key, input bit rnd, output int acc_cyc);
    bit acc;
    int n;
    kl     = key;
    kl_vld = 1'b1;
    n      = 0;
    acc    = 1'b0;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = kl_rdy;
      step(rnd);
      n++;
    end
    if (!acc) chk(1'b0, "accept_timeout", n, 60);
    acc_cyc = cyc;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rkey_vld) && n < 400) begin
      step(rnd);
      n++;
    end
    if (n >= 400) chk(1'b0, "drain_timeout", n, 400);
  endtask

  task automatic run_key(input logic [127:0] key, input bit rnd);
    int a;
    accept_key(key, rnd, a);
    kl_vld = 1'b0;
    drain(rnd);
  endtask

  initial begin
    int a1, a2, n;
    logic [127:0] k1, k2;
    rst      = 1'b1;
    kl       = {$urandom, $urandom, $urandom, $urandom};
    kl_vld   = 1'b1;
    rkey_rdy = 1'b1;

    build_model();
    chk(m_sbox[8'h53] == 8'hed, "model_sbox", m_sbox[8'h53], 8'hed);
    expand_fwd(FIPS_KEY);
    chk(fwd_rk[10] == FIPS_LAST, "model_fwd_r10", fwd_rk[10], FIPS_LAST);
    expand_inv(FIPS_LAST);
    chk(inv_round(9) == FIPS_R9, "model_inv_r9", inv_round(9), FIPS_R9);
    chk(inv_round(0) == FIPS_KEY, "model_inv_r0", inv_round(0), FIPS_KEY);

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    kl_vld = 1'b0;

    // FIPS-197 A.1 with fixed cycle expectations
    @(posedge clk);
    #1;
    kl       = FIPS_LAST;
    kl_vld   = 1'b1;
    rkey_rdy = 1'b1;
    @(negedge clk);
    chk(kl_rdy, "fips_idle", kl_rdy, 1);
    @(posedge clk);
    #1;
    kl_vld = 1'b0;
    @(negedge clk);
    chk(rkey == FIPS_LAST && rkey_idx == 4'd10, "fips_c1", {rkey_idx, rkey}, {4'd10, FIPS_LAST});
    @(negedge clk);
    chk(rkey == FIPS_R9 && rkey_idx == 4'd9, "fips_c2", {rkey_idx, rkey}, {4'd9, FIPS_R9});
    repeat (9) @(negedge clk);
    chk(rkey == FIPS_KEY && rkey_idx == 4'd0 && rkey_last, "fips_c11",
        {rkey_last, rkey_idx, rkey}, {1'b1, 4'd0, FIPS_KEY});
    drain(1'b0);

    // backpressure on the same key
    expand_fwd(FIPS_KEY);
    fwd_on = 1'b1;
    run_key(FIPS_LAST, 1'b1);
    run_key(FIPS_LAST, 1'b1);
    fwd_on = 1'b0;

    // kl_vld pulsed with another key while busy
    accept_key(FIPS_LAST, 1'b1, a1);
    kl_vld = 1'b0;
    repeat (3) step(1'b1);
    kl     = {$urandom, $urandom, $urandom, $urandom};
    kl_vld = 1'b1;
    @(negedge clk);
    chk(!kl_rdy, "busy_ignore", kl_rdy, 0);
    step(1'b1);
    kl_vld = 1'b0;
    drain(1'b1);

    // reset mid-run at idx 5, then a fresh key
    accept_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, a1);
    kl_vld = 1'b0;
    n = 0;
    while (!(rkey_vld && rkey_idx == 4'd5) && n < 30) begin
      step(1'b0);
      n++;
    end
    chk(rkey_vld && rkey_idx == 4'd5, "reach_idx5", {rkey_vld, rkey_idx}, {1'b1, 4'd5});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk(!rkey_vld && kl_rdy, "mid_reset", {rkey_vld, kl_rdy}, {1'b0, 1'b1});
    run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // back-to-back keys with kl_vld held high
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    accept_key(k1, 1'b0, a1);
    accept_key(k2, 1'b0, a2);
    chk(a2 - a1 == 12, "b2b_gap", a2 - a1, 12);
    kl_vld = 1'b0;
    drain(1'b0);

    // forward/inverse cross-check over random cipher keys
    for (int t = 0; t < 1000; t++) begin
      expand_fwd({$urandom, $urandom, $urandom, $urandom});
      fwd_on = 1'b1;
      run_key(fwd_rk[10], (t % 2) == 1);
      fwd_on = 1'b0;
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
